bimodal_predictor: RTL and testbench

BIMODAL_PREDICTOR -- requirements
Module: bimodal_predictor

---
 rtl/bimodal_predictor.sv | 122 ++++++++++++
 tb/tb_bimodal_predictor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bimodal_predictor.sv
// Bimodal branch predictor: direct-mapped table of tagged 2-bit counters with
// stored targets, combinational IF-stage lookup, EX-stage resolve/update,
// registered mispredict/redirect and saturating statistics counters.
module bimodal_predictor #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] Fetch_PC_i,
  output logic        Pred_Taken_o,
  output logic [31:0] Pred_Target_o,
  output logic        Pred_Hit_o,
  input  logic        Ex_Valid_i,
  input  logic [31:0] Ex_PC_i,
  input  logic        BrEn_i,
  input  logic        UncBr_i,
  input  logic        BrBase_i,
  input  logic        Br_Cond_i,
  input  logic [31:0] Ex_Target_i,
  input  logic        Ex_PredTaken_i,
  input  logic [31:0] Ex_PredTarget_i,
  output logic        Mispredict_o,
  output logic [31:0] Redirect_PC_o,
  output logic [31:0] Br_Count_o,
  output logic [31:0] Mispred_Count_o
);

  localparam int unsigned Depth = 1 << INDEX_BITS;
  localparam int unsigned TagW  = 30 - INDEX_BITS;

  logic [Depth-1:0] valid_q;
  logic [TagW-1:0]  tag_q    [Depth];
  logic [31:0]      target_q [Depth];
  logic [1:0]       ctr_q    [Depth];

  logic [INDEX_BITS-1:0] f_idx, ex_idx;
  logic [TagW-1:0]       f_tag, ex_tag;
  logic                  ex_hit, resolve, actual_taken, mispredict;
  logic [1:0]            ctr_d;

  logic        mispredict_q;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  // Jalr needs no special handling: it only matters through the target compare.
  logic unused_bits;
  assign unused_bits = ^{BrBase_i, Fetch_PC_i[1:0], Ex_PC_i[1:0]};

  assign f_idx  = Fetch_PC_i[INDEX_BITS+1:2];
  assign f_tag  = Fetch_PC_i[31:INDEX_BITS+2];
  assign ex_idx = Ex_PC_i[INDEX_BITS+1:2];
  assign ex_tag = Ex_PC_i[31:INDEX_BITS+2];

  // Zero-latency lookup; reads pre-update table contents (no bypass).
  always_comb begin
    Pred_Hit_o    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    Pred_Taken_o  = Pred_Hit_o && ctr_q[f_idx][1];
    Pred_Target_o = Pred_Taken_o ? target_q[f_idx] : Fetch_PC_i + 32'd4;
  end

  // Resolve decode, mispredict detection and next-state for outputs/counters.
  always_comb begin
    resolve      = Ex_Valid_i && (BrEn_i || UncBr_i);
    actual_taken = UncBr_i || (BrEn_i && Br_Cond_i);
    ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    mispredict   = resolve && ((actual_taken != Ex_PredTaken_i) ||
                               (actual_taken && (Ex_PredTarget_i != Ex_Target_i)));
    ctr_d        = ctr_q[ex_idx];
    if (actual_taken && ctr_q[ex_idx] != 2'b11) ctr_d = ctr_q[ex_idx] + 2'd1;
    if (!actual_taken && ctr_q[ex_idx] != 2'b00) ctr_d = ctr_q[ex_idx] - 2'd1;
    redirect_d = redirect_q;
    if (resolve) redirect_d = actual_taken ? Ex_Target_i : Ex_PC_i + 32'd4;
    br_cnt_d = br_cnt_q;
    if (resolve && br_cnt_q != 32'hFFFF_FFFF) br_cnt_d = br_cnt_q + 32'd1;
    mp_cnt_d = mp_cnt_q;
    if (mispredict && mp_cnt_q != 32'hFFFF_FFFF) mp_cnt_d = mp_cnt_q + 32'd1;
  end

  // Table update: train on hit, allocate only on a taken miss.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (resolve) begin
      if (ex_hit) begin
        ctr_q[ex_idx] <= ctr_d;
        if (actual_taken) target_q[ex_idx] <= Ex_Target_i;
      end else if (actual_taken) begin
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= Ex_Target_i;
        ctr_q[ex_idx]    <= UncBr_i ? 2'b11 : 2'b10;
      end
    end
  end

  // Registered flush pulse, redirect PC and statistics.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      br_cnt_q     <= '0;
      mp_cnt_q     <= '0;
    end else begin
      mispredict_q <= mispredict;
      redirect_q   <= redirect_d;
      br_cnt_q     <= br_cnt_d;
      mp_cnt_q     <= mp_cnt_d;
    end
  end

  assign Mispredict_o    = mispredict_q;
  assign Redirect_PC_o   = redirect_q;
  assign Br_Count_o      = br_cnt_q;
  assign Mispred_Count_o = mp_cnt_q;

endmodule

// File: tb/tb_bimodal_predictor.sv
// Bench for bimodal_predictor: directed scenarios then random traffic, all
// checked against an array-based reference model of the predictor behaviour.
module tb_bimodal_predictor;

  localparam int IB    = 6;
  localparam int DEPTH = 1 << IB;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken, pred_hit;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0, br_en = 1'b0, unc_br = 1'b0, br_base = 1'b0, br_cond = 1'b0;
  logic [31:0] ex_pc = '0, ex_target = '0, ex_ptarget = '0;
  logic        ex_ptaken = 1'b0;
  logic        mispredict;
  logic [31:0] redirect_pc, br_count, mp_count;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  bit          m_valid  [DEPTH];
  int unsigned m_tag    [DEPTH];
  logic [31:0] m_target [DEPTH];
  int          m_ctr    [DEPTH];
  bit          m_mis;
  logic [31:0] m_redir, m_br, m_mp;

  bimodal_predictor #(.INDEX_BITS(IB)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .Fetch_PC_i      (fetch_pc),
    .Pred_Taken_o    (pred_taken),
    .Pred_Target_o   (pred_target),
    .Pred_Hit_o      (pred_hit),
    .Ex_Valid_i      (ex_valid),
    .Ex_PC_i         (ex_pc),
    .BrEn_i          (br_en),
    .UncBr_i         (unc_br),
    .BrBase_i        (br_base),
    .Br_Cond_i       (br_cond),
    .Ex_Target_i     (ex_target),
    .Ex_PredTaken_i  (ex_ptaken),
    .Ex_PredTarget_i (ex_ptarget),
    .Mispredict_o    (mispredict),
    .Redirect_PC_o   (redirect_pc),
    .Br_Count_o      (br_count),
    .Mispred_Count_o (mp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_mis = 0; m_redir = '0; m_br = '0; m_mp = '0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit hit, output bit taken,
                                   output logic [31:0] tgt);
    int idx;
    idx   = (pc / 4) % DEPTH;
    hit   = m_valid[idx] && (m_tag[idx] == pc / (4 * DEPTH));
    taken = hit && (m_ctr[idx] >= 2);
    tgt   = taken ? m_target[idx] : pc + 32'd4;
  endfunction

  function automatic void m_update(input bit v, input logic [31:0] pc, input bit br, input bit unc,
                                   input bit cond, input logic [31:0] tgt, input bit pt,
                                   input logic [31:0] ptg);
    bit hit, ltk, taken, mis, resolve;
    logic [31:0] ltg;
    int idx;
    resolve = v && (br || unc);
    taken   = unc || (br && cond);
    mis     = resolve && ((taken != pt) || (taken && ptg != tgt));
    idx     = (pc / 4) % DEPTH;
    m_lookup(pc, hit, ltk, ltg);
    if (resolve) begin
      if (hit) begin
        m_ctr[idx] = taken ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                           : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        if (taken) m_target[idx] = tgt;
      end else if (taken) begin
        m_valid[idx] = 1; m_tag[idx] = pc / (4 * DEPTH); m_target[idx] = tgt;
        m_ctr[idx] = unc ? 3 : 2;
      end
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      if (mis && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      m_redir = taken ? tgt : pc + 32'd4;
    end
    m_mis = mis;
  endfunction

  task automatic chk_lookup();
    bit hit, taken;
    logic [31:0] tgt;
    m_lookup(fetch_pc, hit, taken, tgt);
    chk("pred_hit", {31'd0, pred_hit}, {31'd0, hit});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, taken});
    chk("pred_target", pred_target, tgt);
  endtask

  task automatic chk_regs();
    chk("mispredict", {31'd0, mispredict}, {31'd0, m_mis});
    chk("redirect", redirect_pc, m_redir);
    chk("br_count", br_count, m_br);
    chk("mp_count", mp_count, m_mp);
  endtask

  // One cycle: apply inputs after negedge, check lookup, clock, check registers.
  task automatic step(input bit v, input logic [31:0] pc, input bit br, input bit unc,
                      input bit base, input bit cond, input logic [31:0] tgt, input bit pt,
                      input logic [31:0] ptg, input logic [31:0] fetch);
    @(negedge clk);
    ex_valid = v; ex_pc = pc; br_en = br; unc_br = unc; br_base = base; br_cond = cond;
    ex_target = tgt; ex_ptaken = pt; ex_ptarget = ptg; fetch_pc = fetch;
    #1;
    chk_lookup();
    m_update(v, pc, br, unc, cond, tgt, pt, ptg);
    @(posedge clk);
    #1;
    chk_regs();
  endtask

  task automatic idle(input logic [31:0] fetch);
    step(0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, fetch);
  endtask

  initial begin
    bit hit, taken;
    logic [31:0] tgt, pc, ptg, fetch;
    bit v, br, unc, pt;
    m_reset();
    #1;
    chk_regs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // Cold lookup misses and predicts fall-through
    idle(32'h100);
    chk("cold_target", pred_target, 32'h104);
    // Taken conditional branch, predicted not-taken: allocate with weak-taken
    step(1, 32'h100, 1, 0, 0, 1, 32'h80, 0, 32'h0, 32'h100);
    chk("alloc_redir", redirect_pc, 32'h80);
    // Same branch not-taken three times; first lookup sees pre-update entry
    step(1, 32'h100, 1, 0, 0, 0, 32'h80, 1, 32'h80, 32'h100);
    chk("nt1_redir", redirect_pc, 32'h104);
    step(1, 32'h100, 1, 0, 0, 0, 32'h80, 0, 32'h0, 32'h100);
    step(1, 32'h100, 1, 0, 0, 0, 32'h80, 0, 32'h0, 32'h100);
    idle(32'h100);
    // Jalr at aliasing PC with wrong predicted target evicts 0x100
    step(1, 32'h200, 0, 1, 1, 0, 32'h340, 1, 32'h300, 32'h200);
    chk("jalr_redir", redirect_pc, 32'h340);
    idle(32'h100);
    idle(32'h200);
    chk("jalr_target", pred_target, 32'h340);
    // Hit with correct target, then hit with new target
    step(1, 32'h200, 0, 1, 1, 0, 32'h340, 1, 32'h340, 32'h200);
    step(1, 32'h200, 1, 1, 1, 0, 32'h380, 1, 32'h340, 32'h200);
    idle(32'h200);

    // Saturation of statistics counters via preloaded values
    @(negedge clk);
    force dut.br_cnt_q = 32'hFFFF_FFFF;
    force dut.mp_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt_q;
    release dut.mp_cnt_q;
    m_br = 32'hFFFF_FFFF;
    m_mp = 32'hFFFF_FFFF;
    step(1, 32'h300, 1, 0, 0, 1, 32'h44, 0, 32'h0, 32'h300);
    chk("br_sat", br_count, 32'hFFFF_FFFF);

    // Partial-cycle asynchronous reset mid-stream
    @(negedge clk);
    ex_valid = 0;
    rst_ni = 1'b0;
    m_reset();
    #1;
    chk_regs();
    fetch_pc = 32'h200;
    #1;
    chk_lookup();
    fetch_pc = 32'h300;
    #1;
    chk_lookup();
    rst_ni = 1'b1;
    idle(32'h200);

    // Resolve while reset held across the edge is ignored
    @(negedge clk);
    rst_ni = 1'b0;
    ex_valid = 1; ex_pc = 32'h100; br_en = 0; unc_br = 1; ex_target = 32'h500;
    ex_ptaken = 0; fetch_pc = 32'h100;
    @(posedge clk);
    #1;
    chk_regs();
    @(negedge clk);
    rst_ni = 1'b1;
    ex_valid = 0;
    idle(32'h100);

    // Random traffic over a small aliasing PC set
    for (int n = 0; n < 300; n++) begin
      pc    = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      fetch = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      tgt   = $urandom_range(0, 15) << 4;
      v     = $urandom_range(0, 9) < 8;
      br    = $urandom_range(0, 1);
      unc   = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 1) == 1) begin
        m_lookup(pc, hit, taken, ptg);
        pt = taken;
      end else begin
        pt  = $urandom_range(0, 1);
        ptg = $urandom_range(0, 15) << 4;
      end
      step(v, pc, br, unc, $urandom_range(0, 1), $urandom_range(0, 1), tgt, pt, ptg, fetch);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
